// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - per-move sprite redraw engine: erase old position, draw new, one pixel per clock
module sprite_plotter #(
    parameter int                                   SPRITE_SIZE  = 5,
    parameter logic [SPRITE_SIZE*SPRITE_SIZE-1:0]   SPRITE_BITS  = 25'hE79DEE,
    parameter logic [2:0]                           SPRITE_COLOR = 3'b110,
    parameter logic [2:0]                           BG_COLOR     = 3'b000,
    parameter int                                   SCREEN_W     = 160,
    parameter int                                   SCREEN_H     = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [8:0] y_in,
    input  logic [1:0] dir,
    output logic [7:0] x,
    output logic [8:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int CW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
    localparam int IW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE * SPRITE_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPRITE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_row, r_col, w_row_nxt, w_col_nxt;
    logic [7:0]    r_new_x, r_old_x, w_new_x_nxt;
    logic [8:0]    r_new_y, r_old_y, w_new_y_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic          r_have_old;

    logic [7:0]    r_x;
    logic [8:0]    r_y;
    logic [2:0]    r_color;
    logic          r_plot, r_busy, r_done;

    logic [7:0]    w_base_x;
    logic [8:0]    w_base_y;
    logic [8:0]    w_sum_x;
    logic [9:0]    w_sum_y;
    logic [CW-1:0] w_src_row, w_src_col;
    logic [IW-1:0] w_idx;
    logic          w_bit, w_walk, w_plot_nxt;
    logic [2:0]    w_color_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_new_x_nxt = r_new_x;
        w_new_y_nxt = r_new_y;
        w_dir_nxt   = r_dir;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_new_x_nxt = x_in;
                    w_new_y_nxt = y_in;
                    w_dir_nxt   = dir;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = r_have_old ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                if (r_col == LAST) begin
                    w_col_nxt = '0;
                    if (r_row == LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = (r_state == S_ERASE) ? S_DRAW : S_DONE;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The pixel is computed from next-cycle walk values so it lands in the output registers
    // on the same edge that advances the walk: first pixel appears the cycle after start.
    always_comb begin
        w_walk   = (w_state_nxt == S_ERASE) || (w_state_nxt == S_DRAW);
        w_base_x = (w_state_nxt == S_ERASE) ? r_old_x : w_new_x_nxt;
        w_base_y = (w_state_nxt == S_ERASE) ? r_old_y : w_new_y_nxt;
        w_sum_x  = {1'b0, w_base_x} + 9'(w_col_nxt);
        w_sum_y  = {1'b0, w_base_y} + 10'(w_row_nxt);
        case (w_dir_nxt)
            2'd0: begin w_src_row = w_row_nxt; w_src_col = w_col_nxt;        end
            2'd1: begin w_src_row = w_row_nxt; w_src_col = LAST - w_col_nxt; end
            2'd2: begin w_src_row = w_col_nxt; w_src_col = LAST - w_row_nxt; end
            default: begin w_src_row = w_col_nxt; w_src_col = w_row_nxt;     end
        endcase
        w_idx       = IW'(int'(w_src_row) * SPRITE_SIZE + int'(w_src_col));
        w_bit       = SPRITE_BITS[w_idx];
        w_plot_nxt  = w_walk && (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 10'(SCREEN_H));
        w_color_nxt = ((w_state_nxt == S_DRAW) && w_bit) ? SPRITE_COLOR : BG_COLOR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_new_x    <= '0;
            r_new_y    <= '0;
            r_dir      <= '0;
            r_old_x    <= '0;
            r_old_y    <= '0;
            r_have_old <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_plot     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_new_x <= w_new_x_nxt;
            r_new_y <= w_new_y_nxt;
            r_dir   <= w_dir_nxt;
            if (r_state == S_DONE) begin
                r_old_x    <= r_new_x;
                r_old_y    <= r_new_y;
                r_have_old <= 1'b1;
            end
            if (w_walk) begin
                r_x <= w_sum_x[7:0];
                r_y <= w_sum_y[8:0];
            end
            r_color <= w_walk ? w_color_nxt : BG_COLOR;
            r_plot  <= w_plot_nxt;
            r_busy  <= w_walk;
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;
    assign plot  = r_plot;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - directed self-checking bench for sprite_plotter
module tb_sprite_plotter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x_in  = '0;
    logic [8:0] y_in  = '0;
    logic [1:0] dir   = '0;
    logic [7:0] x;
    logic [8:0] y;
    logic [2:0] color;
    logic       plot, busy, done;

    sprite_plotter dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .dir   (dir),
        .x     (x),
        .y     (y),
        .color (color),
        .plot  (plot),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    localparam int NCYC = 60;

    int n_cmp = 0;
    int n_bad = 0;

    int cap_x     [1:NCYC];
    int cap_y     [1:NCYC];
    int cap_color [1:NCYC];
    int cap_plot  [1:NCYC];
    int cap_busy  [1:NCYC];
    int cap_done  [1:NCYC];

    // Right-facing sprite, hand-decoded from 25'hE79DEE (row 0 on top, column 0 on the left)
    string bmp [5] = '{".XXX.", "XXXX.", "XXX..", "XXXX.", ".XXX."};

    function automatic int model_color(input int r, input int c);
        string s;
        s = bmp[r];
        return (s[c] == "X") ? 6 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // start is high during cycle 0; cycle k output is captured at the negedge of cycle k
    task automatic run(input logic [7:0] nx, input logic [8:0] ny, input logic [1:0] nd,
                       input int pulse_at, input int reset_at);
        @(posedge clock);
        #1;
        start = 1'b1;
        x_in  = nx;
        y_in  = ny;
        dir   = nd;
        @(posedge clock);
        for (int k = 1; k <= NCYC; k++) begin
            #1;
            start = (k == pulse_at);
            reset = (k == reset_at);
            if (k == pulse_at) begin
                x_in = 8'd77;
                y_in = 9'd66;
                dir  = 2'd3;
            end
            @(negedge clock);
            cap_x[k]     = int'(x);
            cap_y[k]     = int'(y);
            cap_color[k] = int'(color);
            cap_plot[k]  = int'(plot);
            cap_busy[k]  = int'(busy);
            cap_done[k]  = int'(done);
            @(posedge clock);
        end
        #1;
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_walk(input string tag, input int k0, input int bx, input int by,
                              input bit is_draw);
        for (int p = 0; p < 25; p++) begin
            int r, c, k;
            r = p / 5;
            c = p % 5;
            k = k0 + p;
            check($sformatf("%s_x%0d", tag, p), cap_x[k], (bx + c) % 256);
            check($sformatf("%s_y%0d", tag, p), cap_y[k], (by + r) % 512);
            check($sformatf("%s_plot%0d", tag, p), cap_plot[k],
                  ((bx + c) < 160 && (by + r) < 120) ? 1 : 0);
            check($sformatf("%s_color%0d", tag, p), cap_color[k],
                  is_draw ? model_color(r, c) : 0);
        end
    endtask

    task automatic check_done(input string tag, input int kd);
        for (int k = 1; k <= NCYC; k++) begin
            check($sformatf("%s_done%0d", tag, k), cap_done[k], (k == kd) ? 1 : 0);
            check($sformatf("%s_busy%0d", tag, k), cap_busy[k], (k < kd) ? 1 : 0);
            if (k >= kd)
                check($sformatf("%s_idleplot%0d", tag, k), cap_plot[k], 0);
        end
    endtask

    initial begin
        int cnt;

        do_reset();
        @(negedge clock);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_color", int'(color), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // first move after reset: draw only
        run(8'd10, 9'd20, 2'd0, 0, 0);
        check_walk("t1", 1, 10, 20, 1'b1);
        check_done("t1", 26);
        check("t1_px10_20", cap_color[1], 0);
        check("t1_px11_20", cap_color[2], 6);
        check("t1_px13_22", cap_color[14], 0);

        // erase at old position then draw at new
        run(8'd11, 9'd20, 2'd0, 0, 0);
        check_walk("t2e", 1, 10, 20, 1'b0);
        check_walk("t2d", 26, 11, 20, 1'b1);
        check_done("t2", 51);

        // bottom-right clipping
        do_reset();
        run(8'd158, 9'd118, 2'd0, 0, 0);
        cnt = 0;
        for (int k = 1; k <= 25; k++) cnt += cap_plot[k];
        check("t3_nplot", cnt, 4);
        check("t3_c158_118", cap_color[1], 0);
        check("t3_c159_118", cap_color[2], 6);
        check("t3_c158_119", cap_color[6], 6);
        check("t3_c159_119", cap_color[7], 6);
        check("t3_xtrunc", cap_x[3], 160);
        check_walk("t3", 1, 158, 118, 1'b1);
        check_done("t3", 26);

        // directions at the origin
        do_reset();
        run(8'd0, 9'd0, 2'd1, 0, 0);
        check("t4l_0_1_x", cap_x[6], 0);
        check("t4l_0_1_y", cap_y[6], 1);
        check("t4l_0_1", cap_color[6], 0);
        check("t4l_4_1", cap_color[10], 6);
        do_reset();
        run(8'd0, 9'd0, 2'd2, 0, 0);
        check("t4u_2_0", cap_color[3], 0);
        check("t4u_2_4_x", cap_x[23], 2);
        check("t4u_2_4_y", cap_y[23], 4);
        check("t4u_2_4", cap_color[23], 6);
        do_reset();
        run(8'd0, 9'd0, 2'd3, 0, 0);
        check("t4d_2_4", cap_color[23], 0);
        check("t4d_2_0", cap_color[3], 6);
        check_done("t4d", 26);

        // start (with changed inputs) pulsed mid-draw is ignored
        do_reset();
        run(8'd10, 9'd20, 2'd0, 10, 0);
        check_walk("t5", 1, 10, 20, 1'b1);
        check_done("t5", 26);

        // reset during erase aborts and clears have_old
        do_reset();
        run(8'd30, 9'd30, 2'd0, 0, 0);
        run(8'd40, 9'd40, 2'd0, 0, 12);
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("t6_eplot%0d", k), cap_plot[k], 1);
            check($sformatf("t6_ex%0d", k), cap_x[k], 30 + (k - 1) % 5);
        end
        check("t6_plot13", cap_plot[13], 0);
        check("t6_busy13", cap_busy[13], 0);
        check("t6_done13", cap_done[13], 0);
        cnt = 0;
        for (int k = 13; k <= NCYC; k++) cnt += cap_done[k] + cap_plot[k] + cap_busy[k];
        check("t6_quiet", cnt, 0);
        run(8'd5, 9'd5, 2'd0, 0, 0);
        check_walk("t6", 1, 5, 5, 1'b1);
        check_done("t6", 26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
